// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the counter sequencer block.
// Holds the sequencer state enum and the default counter/pass-count widths.
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH = 3;
  localparam int DEFAULT_LOOPW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit count register with load/step/clear/hold controls.
// qb is registered from the same next value as q, so it always equals ~q.
module count_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             hold,
  input  logic             step_up,
  input  logic             step_down,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] next_q;

  // Clear wins over load, load over hold, and hold over any step request.
  always_comb begin
    next_q = q;
    if (clear)          next_q = '0;
    else if (load)      next_q = load_value;
    else if (hold)      next_q = q;
    else if (step_up)   next_q = q + 1'b1;
    else if (step_down) next_q = q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= '0;
      qb <= '1;
    end else begin
      q  <= next_q;
      qb <= ~next_q;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Bounded up/down counter sequencer: runs lo..hi (or hi..lo) for a number of
// passes, with pause, abort, wrap/done/err pulses and a synchronous reset.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LOOPW = DEFAULT_LOOPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [LOOPW-1:0] loops,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  state_t state, state_next;

  logic             dir_r;
  logic [WIDTH-1:0] lo_r, hi_r;
  logic [LOOPW-1:0] loops_r, passes, passes_inc;
  logic [WIDTH-1:0] start_val, end_val, load_value;
  logic             start_ok, start_bad, at_end, last_pass;
  logic             accept, reload;
  logic             core_clear, core_load, core_hold, core_up, core_down;

  assign start_ok   = start && (lo <= hi);
  assign start_bad  = start && (lo > hi);
  assign start_val  = dir_r ? lo_r : hi_r;
  assign end_val    = dir_r ? hi_r : lo_r;
  assign at_end     = (q == end_val);
  assign passes_inc = passes + 1'b1;
  // Free-run (loops==0) never finishes, so the pass counter may wrap freely.
  assign last_pass  = (loops_r != '0) && (passes_inc == loops_r);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_next = ST_RUN;
      ST_RUN: begin
        if (abort)                    state_next = ST_IDLE;
        else if (pause)               state_next = ST_PAUSE;
        else if (at_end && last_pass) state_next = ST_DONE;
      end
      ST_PAUSE: begin
        if (abort)       state_next = ST_IDLE;
        else if (!pause) state_next = ST_RUN;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    accept     = 1'b0;
    reload     = 1'b0;
    core_clear = 1'b0;
    core_load  = 1'b0;
    core_hold  = 1'b0;
    core_up    = 1'b0;
    core_down  = 1'b0;
    load_value = start_val;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          accept     = 1'b1;
          core_load  = 1'b1;
          load_value = dir ? lo : hi;
        end else begin
          core_hold = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort)      core_clear = 1'b1;
        else if (pause) core_hold  = 1'b1;
        else if (at_end) begin
          if (last_pass) core_hold = 1'b1;
          else begin
            reload    = 1'b1;
            core_load = 1'b1;
          end
        end else begin
          core_up   = dir_r;
          core_down = !dir_r;
        end
      end
      ST_PAUSE: begin
        if (abort) core_clear = 1'b1;
        else       core_hold  = 1'b1;
      end
      ST_DONE:  core_hold = 1'b1;
      default:  core_hold = 1'b1;
    endcase
  end

  // Config latches, pass counter and the registered wrap/err pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_r   <= 1'b0;
      lo_r    <= '0;
      hi_r    <= '0;
      loops_r <= '0;
      passes  <= '0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wrap <= reload;
      err  <= (state == ST_IDLE) && start_bad;
      if (accept) begin
        dir_r   <= dir;
        lo_r    <= lo;
        hi_r    <= hi;
        loops_r <= loops;
        passes  <= '0;
      end else if (reload) begin
        passes <= passes_inc;
      end
    end
  end

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .clear      (core_clear),
    .load       (core_load),
    .load_value (load_value),
    .hold       (core_hold),
    .step_up    (core_up),
    .step_down  (core_down),
    .q          (q),
    .qb         (qb)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed scenarios plus random
// stimulus, checked against an arithmetic reference model of the sequencer.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0, dir = 1'b0;
  logic [2:0] lo = '0, hi = '0;
  logic [3:0] loops = '0;
  logic [2:0] q, qb;
  logic       busy, done, wrap, err;

  typedef struct packed {
    logic [2:0] q;
    logic [2:0] qb;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   cycleNo = 0;

  // Reference model state: plain integers, one "sequence in flight" view.
  bit   mActive = 0, mPaused = 0, mFinishing = 0;
  int   mCur = 0, mStartVal = 0, mEndVal = 0, mStep = 0;
  int   mPasses = 0, mLoops = 0;

  counter_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .pause (pause),
    .abort (abort),
    .dir   (dir),
    .lo    (lo),
    .hi    (hi),
    .loops (loops),
    .q     (q),
    .qb    (qb),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Predict the outputs after the next clock edge from the inputs just driven.
  task automatic modelStep(input bit r, s, p, a, d, input bit [2:0] l, h,
                           input bit [3:0] n, output exp_t e);
    bit eWrap = 0, eErr = 0;
    if (r) begin
      mActive = 0; mPaused = 0; mFinishing = 0; mCur = 0;
    end else if (mFinishing) begin
      mFinishing = 0; mActive = 0;
    end else if (!mActive) begin
      if (s) begin
        if (l <= h) begin
          mActive   = 1; mPaused = 0;
          mStartVal = d ? int'(l) : int'(h);
          mEndVal   = d ? int'(h) : int'(l);
          mStep     = d ? 1 : -1;
          mLoops    = int'(n);
          mPasses   = 0;
          mCur      = mStartVal;
        end else begin
          eErr = 1;
        end
      end
    end else if (a) begin
      mActive = 0; mPaused = 0; mCur = 0;
    end else if (mPaused) begin
      if (!p) mPaused = 0;
    end else if (p) begin
      mPaused = 1;
    end else if (mCur == mEndVal) begin
      mPasses++;
      if (mLoops != 0 && mPasses == mLoops) mFinishing = 1;
      else begin
        mCur  = mStartVal;
        eWrap = 1;
      end
    end else begin
      mCur += mStep;
    end
    e.q    = 3'(mCur);
    e.qb   = ~3'(mCur);
    e.busy = mActive;
    e.done = mFinishing;
    e.wrap = eWrap;
    e.err  = eErr;
  endtask

  task automatic applyStimulus(input bit r, s, p, a, d, input bit [2:0] l, h,
                               input bit [3:0] n);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; pause = p; abort = a; dir = d;
    lo = l; hi = h; loops = n;
    modelStep(r, s, p, a, d, l, h, n, e);
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int count);
    for (int i = 0; i < count; i++) applyStimulus(0, 0, 0, 0, 0, 3'd0, 3'd0, 4'd0);
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t act;
    act = '{q: q, qb: qb, busy: busy, done: done, wrap: wrap, err: err};
    assertCount++;
    if (act !== e) begin
      failCount++;
      $display("[TB] FAIL outputs cycle %0d: got q=%0d qb=%0d busy=%b done=%b wrap=%b err=%b, expected q=%0d qb=%0d busy=%b done=%b wrap=%b err=%b",
               cycleNo, act.q, act.qb, act.busy, act.done, act.wrap, act.err,
               e.q, e.qb, e.busy, e.done, e.wrap, e.err);
    end
    assertCount++;
    if ((int'(done) + int'(wrap) + int'(err)) > 1) begin
      failCount++;
      $display("[TB] FAIL pulse_exclusive cycle %0d: got done=%b wrap=%b err=%b, expected at most one",
               cycleNo, done, wrap, err);
    end
  endtask

  // Monitor: compare every cycle that has a pending prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 3'd0, 3'd0, 4'd0);
    idleCycles(2);

    // Two up-passes 2..5.
    applyStimulus(0, 1, 0, 0, 1, 3'd2, 3'd5, 4'd2);
    idleCycles(12);

    // Free-run down 6..1 with a pause window and a late abort.
    applyStimulus(0, 1, 0, 0, 0, 3'd1, 3'd6, 4'd0);
    for (int k = 1; k <= 14; k++)
      applyStimulus(0, 0, (k >= 3 && k <= 5), (k == 12), 0, 3'd0, 3'd0, 4'd0);
    idleCycles(2);

    // Rejected start, then a start issued mid-run that must be ignored.
    applyStimulus(0, 1, 0, 0, 1, 3'd5, 3'd3, 4'd1);
    idleCycles(2);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 3'd3, 4'd1);
    idleCycles(1);
    applyStimulus(0, 1, 0, 0, 0, 3'd6, 3'd2, 4'd3);
    applyStimulus(0, 1, 0, 0, 0, 3'd1, 3'd7, 4'd3);
    idleCycles(6);

    // Degenerate range lo==hi with three passes, then free-running.
    applyStimulus(0, 1, 0, 0, 1, 3'd4, 3'd4, 4'd3);
    idleCycles(6);
    applyStimulus(0, 1, 0, 0, 1, 3'd4, 3'd4, 4'd0);
    idleCycles(4);
    applyStimulus(0, 0, 0, 1, 0, 3'd0, 3'd0, 4'd0);

    // Reset mid-run together with pause and abort, then a fresh start.
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 3'd7, 4'd0);
    idleCycles(3);
    applyStimulus(1, 1, 1, 1, 1, 3'd1, 3'd2, 4'd1);
    applyStimulus(0, 1, 0, 0, 1, 3'd1, 3'd2, 4'd1);
    idleCycles(4);

    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
    idleCycles(6);

    repeat (3) @(posedge clk);
    #2;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
